// File: rtl/tpu_mmio_master.sv
// MMIO initiator that loads A/B into tpu_top, starts it, polls STATUS.done and streams C back out.
// Optional build macro TPU_MMIO_ID_CHECK_EN adds an ID register check before any write.
module tpu_mmio_master #(
  parameter int          N           = 4,
  parameter int          DATA_W      = 8,
  parameter int          SUM_W       = 32,
  parameter logic [15:0] TPU_BASE    = 16'h0000,
  parameter int          POLL_LIMIT  = 1024,
  parameter logic [31:0] EXPECTED_ID = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_start,
  output logic              busy,
  output logic              done,
  output logic              err,
  // Streams: a beat transfers on a rising edge where valid && ready are both 1.
  input  logic              op_valid,
  input  logic [DATA_W-1:0] op_data,
  output logic              op_ready,
  output logic              res_valid,
  output logic [SUM_W-1:0]  res_data,
  input  logic              res_ready,
  output logic              mmio_wr,
  output logic              mmio_rd,
  output logic [15:0]       mmio_addr,
  output logic [31:0]       mmio_wdata,
  output logic [3:0]        mmio_wstrb,
  input  logic [31:0]       mmio_rdata,
  input  logic              mmio_ready
);

  localparam int NN     = N * N;
  localparam int CNT_W  = $clog2(NN + 1);
  localparam int POLL_W = $clog2(POLL_LIMIT + 1);

  localparam logic [15:0] ID_ADDR     = TPU_BASE;
  localparam logic [15:0] CTRL_ADDR   = TPU_BASE + 16'h0008;
  localparam logic [15:0] STATUS_ADDR = TPU_BASE + 16'h000C;
  localparam logic [15:0] A_BASE      = TPU_BASE + 16'h0100;
  localparam logic [15:0] B_BASE      = TPU_BASE + 16'h0200;
  localparam logic [15:0] C_BASE      = TPU_BASE + 16'h0300;

  localparam logic [CNT_W-1:0]  LAST_ELEM = CNT_W'(NN);
  localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_LIMIT);

  typedef enum logic [3:0] {
    S_IDLE,
`ifdef TPU_MMIO_ID_CHECK_EN
    S_ID_CHK,
`endif
    S_LOAD_A,
    S_LOAD_B,
    S_START,
    S_POLL,
    S_READ_C,
    S_RES_HOLD,
    S_FIN,
    S_ERR
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [POLL_W-1:0]  poll_cnt;
  logic               bus_busy;
  logic               bus_done;
  logic               unused_ok;

  assign bus_busy   = mmio_wr | mmio_rd;
  assign bus_done   = bus_busy & mmio_ready;
  assign mmio_wstrb = 4'hF;
  // Operands are only taken when the previous write has finished, so at most one access is in flight.
  assign op_ready   = ((state == S_LOAD_A) || (state == S_LOAD_B)) && !mmio_wr;
  assign unused_ok  = ^{mmio_rdata, EXPECTED_ID};

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      res_valid  <= 1'b0;
      res_data   <= '0;
      mmio_wr    <= 1'b0;
      mmio_rd    <= 1'b0;
      mmio_addr  <= '0;
      mmio_wdata <= '0;
      cnt        <= '0;
      poll_cnt   <= '0;
    end else begin
      done <= 1'b0;
      if (bus_done) begin
        mmio_wr <= 1'b0;
        mmio_rd <= 1'b0;
      end

      unique case (state)
        S_IDLE: begin
          if (cmd_start) begin
            busy     <= 1'b1;
            err      <= 1'b0;
            cnt      <= '0;
            poll_cnt <= '0;
`ifdef TPU_MMIO_ID_CHECK_EN
            state    <= S_ID_CHK;
`else
            state    <= S_LOAD_A;
`endif
          end
        end

`ifdef TPU_MMIO_ID_CHECK_EN
        S_ID_CHK: begin
          if (bus_done) begin
            if (mmio_rdata != EXPECTED_ID) begin
              err   <= 1'b1;
              state <= S_ERR;
            end else begin
              state <= S_LOAD_A;
            end
          end else if (!bus_busy) begin
            mmio_rd   <= 1'b1;
            mmio_addr <= ID_ADDR;
          end
        end
`endif

        S_LOAD_A, S_LOAD_B: begin
          if (bus_done && (cnt == LAST_ELEM)) begin
            cnt   <= '0;
            state <= (state == S_LOAD_A) ? S_LOAD_B : S_START;
          end else if (op_valid && op_ready) begin
            mmio_wr    <= 1'b1;
            mmio_addr  <= ((state == S_LOAD_A) ? A_BASE : B_BASE) + 16'(cnt);
            mmio_wdata <= 32'(op_data);
            cnt        <= cnt + CNT_W'(1);
          end
        end

        S_START: begin
          if (bus_done) begin
            poll_cnt <= '0;
            state    <= S_POLL;
          end else if (!bus_busy) begin
            mmio_wr    <= 1'b1;
            mmio_addr  <= CTRL_ADDR;
            mmio_wdata <= 32'h1;
          end
        end

        S_POLL: begin
          if (bus_done) begin
            if (mmio_rdata[1]) begin
              cnt   <= '0;
              state <= S_READ_C;
            end else if ((poll_cnt + POLL_W'(1)) == POLL_LAST) begin
              err   <= 1'b1;
              state <= S_ERR;
            end else begin
              poll_cnt <= poll_cnt + POLL_W'(1);
            end
          end else if (!bus_busy) begin
            mmio_rd   <= 1'b1;
            mmio_addr <= STATUS_ADDR;
          end
        end

        S_READ_C: begin
          if (bus_done) begin
            res_data  <= mmio_rdata[SUM_W-1:0];
            res_valid <= 1'b1;
            cnt       <= cnt + CNT_W'(1);
            state     <= S_RES_HOLD;
          end else if (!bus_busy) begin
            mmio_rd   <= 1'b1;
            mmio_addr <= C_BASE + (16'(cnt) << 2);
          end
        end

        // Single-entry result buffer: the next C read waits until this word is taken.
        S_RES_HOLD: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            if (cnt == LAST_ELEM) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= S_FIN;
            end else begin
              state <= S_READ_C;
            end
          end
        end

        S_ERR: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_FIN;
        end

        S_FIN: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tpu_mmio_master.sv
// Bench for tpu_mmio_master: bus/TPU model with configurable latency, scoreboard queues for bus accesses and results.
module tb_tpu_mmio_master;
  localparam int          NN         = 16;
  localparam int          POLL_LIM   = 8;
  localparam int          DONE_AFTER = 3;
  localparam logic [31:0] EXP_ID     = 32'hA5A5_0001;

  logic        clk;
  logic        rst;
  logic        cmd_start;
  logic        busy;
  logic        done;
  logic        err;
  logic        op_valid;
  logic [7:0]  op_data;
  logic        op_ready;
  logic        res_valid;
  logic [31:0] res_data;
  logic        res_ready;
  logic        mmio_wr;
  logic        mmio_rd;
  logic [15:0] mmio_addr;
  logic [31:0] mmio_wdata;
  logic [3:0]  mmio_wstrb;
  logic [31:0] mmio_rdata = 32'h0;
  logic        mmio_ready = 1'b0;

  int n_cmp = 0;
  int n_fail = 0;

  logic [7:0]  b_tab [16] = '{8'd2, 8'd1, 8'd0, 8'd3, 8'd1, 8'd0, 8'd2, 8'd1,
                              8'd3, 8'd1, 8'd1, 8'd0, 8'd0, 8'd2, 8'd1, 8'd1};
  logic [7:0]  ops [32];
  logic [31:0] c_exp [16];

  logic [48:0] exp_bus_q[$];
  logic [31:0] exp_res_q[$];

  // bus model knobs (written by the stimulus thread only)
  int          lat = 0;
  bit          status_never = 1'b0;
  logic [31:0] id_value = EXP_ID;

  // bus model state (written by the model only)
  int          wait_cnt = 0;
  int          held = 0;
  int          status_reads = 0;
  int          obs_cnt = 0;
  int          stab_viol = 0;
  int          both_viol = 0;
  int          rd_res_viol = 0;
  int          wstrb_viol = 0;
  logic [48:0] last_acc = '0;
  logic [48:0] obs_log [1024];
  int          obs_hold [1024];
  logic [31:0] mem [1024];

  tpu_mmio_master #(
    .N(4), .DATA_W(8), .SUM_W(32), .TPU_BASE(16'h0000),
    .POLL_LIMIT(POLL_LIM), .EXPECTED_ID(EXP_ID)
  ) dut (
    .clk(clk), .rst(rst), .cmd_start(cmd_start), .busy(busy), .done(done), .err(err),
    .op_valid(op_valid), .op_data(op_data), .op_ready(op_ready),
    .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
    .mmio_wr(mmio_wr), .mmio_rd(mmio_rd), .mmio_addr(mmio_addr), .mmio_wdata(mmio_wdata),
    .mmio_wstrb(mmio_wstrb), .mmio_rdata(mmio_rdata), .mmio_ready(mmio_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Slave + TPU model: answers after `lat` extra cycles, logs every completed access.
  always @(posedge clk) begin
    #1;
    if (rst) begin
      mmio_ready = 1'b0;
      wait_cnt = 0;
      held = 0;
    end else begin
      if (cmd_start) status_reads = 0;
      if (mmio_wstrb !== 4'hF) wstrb_viol++;
      if (mmio_wr && mmio_rd) both_viol++;
      if (mmio_rd && res_valid) rd_res_viol++;
      if (mmio_wr || mmio_rd) begin
        if (held > 0 && {mmio_wr, mmio_addr, mmio_wdata} !== last_acc) stab_viol++;
        last_acc = {mmio_wr, mmio_addr, mmio_wdata};
        held++;
        if (wait_cnt == lat) begin
          mmio_ready = 1'b1;
          wait_cnt = 0;
          obs_log[obs_cnt] = {mmio_wr, mmio_addr, mmio_wr ? mmio_wdata : 32'h0};
          obs_hold[obs_cnt] = held;
          obs_cnt++;
          held = 0;
          if (mmio_wr) begin
            mem[mmio_addr[9:0]] = mmio_wdata;
          end else if (mmio_addr == 16'h0000) begin
            mmio_rdata = id_value;
          end else if (mmio_addr == 16'h000C) begin
            status_reads++;
            mmio_rdata = (!status_never && status_reads >= DONE_AFTER) ? 32'h2 :
                         (status_never ? 32'h0 : 32'h1);
          end else if (mmio_addr >= 16'h0300 && mmio_addr < 16'h0340) begin
            int k, i, j;
            logic [31:0] s;
            k = int'(mmio_addr - 16'h0300) >> 2;
            i = k / 4;
            j = k % 4;
            s = 0;
            for (int t = 0; t < 4; t++) s += mem[256 + i * 4 + t] * mem[512 + t * 4 + j];
            mmio_rdata = s;
          end else begin
            mmio_rdata = 32'hDEAD_BEEF;
          end
        end else begin
          mmio_ready = 1'b0;
          wait_cnt++;
        end
      end else begin
        mmio_ready = 1'b0;
        held = 0;
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1; cmd_start = 1'b0; op_valid = 1'b0; op_data = 8'h0; res_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", err); end
    n_cmp++; if (op_ready !== 1'b0) begin n_fail++; $display("FAIL reset_op_ready got %b want 0", op_ready); end
    n_cmp++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_res_valid got %b want 0", res_valid); end
    n_cmp++; if ({mmio_wr, mmio_rd} !== 2'b00) begin n_fail++; $display("FAIL reset_strobes got %b want 00", {mmio_wr, mmio_rd}); end
    n_cmp++; if (mmio_addr !== 16'h0) begin n_fail++; $display("FAIL reset_addr got %h want 0000", mmio_addr); end
    n_cmp++; if (mmio_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_wdata got %h want 0", mmio_wdata); end
    n_cmp++; if (mmio_wstrb !== 4'hF) begin n_fail++; $display("FAIL reset_wstrb got %h want f", mmio_wstrb); end
    n_cmp++; if (res_data !== 32'h0) begin n_fail++; $display("FAIL reset_res_data got %h want 0", res_data); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  // mode 0: full job, 1: STATUS never done, 2: ID mismatch
  task automatic run_job(input int mode, input int res_delay, input bit gaps, input string tag);
    int op_idx = 0, hold = 0, cyc = 0, dones = 0, post = 0, ridx = 0, n_status = 0;
    bit seen_done = 1'b0, holding = 1'b0;
    logic [31:0] held_data = '0, want_r;
    logic [48:0] got, want;
    int sv0 = stab_viol, bv0 = both_viol, rv0 = rd_res_viol, wv0 = wstrb_viol;
    exp_bus_q.delete();
    exp_res_q.delete();
`ifdef TPU_MMIO_ID_CHECK_EN
    exp_bus_q.push_back({1'b0, 16'h0000, 32'h0});
`endif
    if (mode != 2) begin
      for (int k = 0; k < 32; k++)
        exp_bus_q.push_back({1'b1, (k < 16) ? 16'(16'h100 + k) : 16'(16'h200 + k - 16), 32'(ops[k])});
      exp_bus_q.push_back({1'b1, 16'h0008, 32'h1});
      n_status = (mode == 1) ? POLL_LIM : DONE_AFTER;
      for (int k = 0; k < n_status; k++) exp_bus_q.push_back({1'b0, 16'h000C, 32'h0});
      if (mode == 0) begin
        for (int k = 0; k < NN; k++) begin
          exp_bus_q.push_back({1'b0, 16'(16'h300 + 4 * k), 32'h0});
          exp_res_q.push_back(c_exp[k]);
        end
      end
    end
    ridx = obs_cnt;
    cmd_start = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL %s busy_after_start got %b want 1", tag, busy); end
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL %s err_cleared got %b want 0", tag, err); end
    while (post < 6 && cyc < 3000) begin
      if (op_idx < 32) begin
        op_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
        op_data = ops[op_idx];
      end else begin
        op_valid = 1'b0;
        op_data = 8'h0;
      end
      if (op_valid && op_ready) op_idx++;
      cmd_start = (mode == 0 && cyc == 12);
      if (res_valid) begin
        if (holding) begin
          n_cmp++;
          if (res_data !== held_data) begin n_fail++; $display("FAIL %s res_stable got %h want %h", tag, res_data, held_data); end
        end
        if (hold < res_delay) begin
          res_ready = 1'b0; hold++; holding = 1'b1; held_data = res_data;
        end else begin
          res_ready = 1'b1; hold = 0; holding = 1'b0;
          n_cmp++;
          if (exp_res_q.size() == 0) begin
            n_fail++; $display("FAIL %s extra_result got %h", tag, res_data);
          end else begin
            want_r = exp_res_q.pop_front();
            if (res_data !== want_r) begin n_fail++; $display("FAIL %s result got %0d want %0d", tag, res_data, want_r); end
          end
        end
      end else begin
        res_ready = (res_delay == 0);
        hold = 0;
        holding = 1'b0;
      end
      if (done) begin dones++; seen_done = 1'b1; end
      if (seen_done) post++;
      while (ridx < obs_cnt) begin
        got = obs_log[ridx];
        n_cmp++;
        if (exp_bus_q.size() == 0) begin
          n_fail++; $display("FAIL %s extra_access got %h", tag, got);
        end else begin
          want = exp_bus_q.pop_front();
          if (got !== want) begin n_fail++; $display("FAIL %s bus_access got %h want %h", tag, got, want); end
        end
        n_cmp++;
        if (obs_hold[ridx] != lat + 1) begin n_fail++; $display("FAIL %s strobe_cycles got %0d want %0d", tag, obs_hold[ridx], lat + 1); end
        ridx++;
      end
      cyc++;
      @(negedge clk);
    end
    op_valid = 1'b0;
    res_ready = 1'b0;
    cmd_start = 1'b0;
    n_cmp++; if (!seen_done) begin n_fail++; $display("FAIL %s job_timeout got %0d cycles want done", tag, cyc); end
    n_cmp++; if (dones != 1) begin n_fail++; $display("FAIL %s done_pulses got %0d want 1", tag, dones); end
    n_cmp++; if (err !== (mode != 0)) begin n_fail++; $display("FAIL %s err got %b want %b", tag, err, mode != 0); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL %s busy_at_end got %b want 0", tag, busy); end
    n_cmp++; if (exp_bus_q.size() != 0) begin n_fail++; $display("FAIL %s missing_accesses got %0d left want 0", tag, exp_bus_q.size()); end
    n_cmp++; if (exp_res_q.size() != 0) begin n_fail++; $display("FAIL %s missing_results got %0d left want 0", tag, exp_res_q.size()); end
    n_cmp++; if (op_idx != ((mode == 2) ? 0 : 32)) begin n_fail++; $display("FAIL %s operands_taken got %0d", tag, op_idx); end
    n_cmp++; if (stab_viol != sv0) begin n_fail++; $display("FAIL %s strobe_unstable got %0d want 0", tag, stab_viol - sv0); end
    n_cmp++; if (both_viol != bv0) begin n_fail++; $display("FAIL %s wr_and_rd got %0d want 0", tag, both_viol - bv0); end
    n_cmp++; if (rd_res_viol != rv0) begin n_fail++; $display("FAIL %s read_while_res_valid got %0d want 0", tag, rd_res_viol - rv0); end
    n_cmp++; if (wstrb_viol != wv0) begin n_fail++; $display("FAIL %s wstrb got %0d bad cycles want 0", tag, wstrb_viol - wv0); end
  endtask

  task automatic test_nominal();
    lat = 0;
    run_job(0, 0, 1'b0, "nominal");
  endtask

  task automatic test_backpressure();
    lat = 0;
    run_job(0, 5, 1'b1, "backpressure");
  endtask

  task automatic test_slow_slave();
    lat = 3;
    run_job(0, 0, 1'b0, "slow_slave");
    lat = 0;
  endtask

  task automatic test_poll_timeout();
    status_never = 1'b1;
    run_job(1, 0, 1'b0, "poll_timeout");
    status_never = 1'b0;
  endtask

  task automatic test_reset_mid_job();
    int op_idx = 0, cyc = 0, dones = 0;
    cmd_start = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
    while (op_idx < 21 && cyc < 500) begin
      op_valid = 1'b1;
      op_data = ops[op_idx];
      if (op_ready) op_idx++;
      @(negedge clk);
      cyc++;
    end
    n_cmp++; if (op_idx != 21) begin n_fail++; $display("FAIL rst_mid reached_load_b got %0d want 21", op_idx); end
    op_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if ({mmio_wr, mmio_rd} !== 2'b00) begin n_fail++; $display("FAIL rst_mid strobes got %b want 00", {mmio_wr, mmio_rd}); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid busy got %b want 0", busy); end
    n_cmp++; if (op_ready !== 1'b0) begin n_fail++; $display("FAIL rst_mid op_ready got %b want 0", op_ready); end
    if (done) dones++;
    rst = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (done) dones++;
    end
    n_cmp++; if (dones != 0) begin n_fail++; $display("FAIL rst_mid done_pulses got %0d want 0", dones); end
    run_job(0, 0, 1'b0, "rerun_after_reset");
  endtask

`ifdef TPU_MMIO_ID_CHECK_EN
  task automatic test_id_check();
    id_value = 32'h0;
    run_job(2, 0, 1'b0, "id_mismatch");
    id_value = EXP_ID;
    run_job(0, 0, 1'b0, "id_match");
  endtask
`endif

  initial begin
    for (int k = 0; k < 16; k++) begin
      ops[k] = 8'(k + 1);
      ops[16 + k] = b_tab[k];
    end
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        c_exp[i * 4 + j] = 0;
        for (int t = 0; t < 4; t++)
          c_exp[i * 4 + j] += 32'(ops[i * 4 + t]) * 32'(ops[16 + t * 4 + j]);
      end
    end
    test_reset();
    test_nominal();
    test_backpressure();
    test_slow_slave();
    test_poll_timeout();
    test_reset_mid_job();
`ifdef TPU_MMIO_ID_CHECK_EN
    test_id_check();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/tpu_mmio_master.md
Name: tpu_mmio_master

Overview:
Hardware MMIO initiator for tpu_top. It replaces the software/host sequence that drives the accelerator's register window. It accepts a streamed A then B operand set and writes both into the A/B windows. It then writes CTRL.start, polls STATUS.done and reads the C window back. The C words are emitted on a result stream. It sits between a DMA/stream fabric and the tpu_top MMIO port.

Parameters:
N, 4, matrix dimension.
DATA_W, 8, operand element width (zero-extended onto mmio_wdata).
SUM_W, 32, result width (<=32, taken from mmio_rdata[SUM_W-1:0]).
TPU_BASE, 16'h0000, base of TPU window: CTRL +0x08, STATUS +0x0C, A +0x100, B +0x200, C +0x300.
POLL_LIMIT, 1024, max STATUS reads before timeout error.
EXPECTED_ID, 32'h0000_0000, ID value compared only when TPU_MMIO_ID_CHECK_EN is defined.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cmd_start  in  1  one-cycle request; honoured only in IDLE
busy  out  1  high from accepted start until done pulse
done  out  1  one-cycle pulse at end of job
err  out  1  sticky error, cleared by next accepted cmd_start
op_valid  in  1  operand element valid
op_data  in  DATA_W  operand element: A row-major, then B row-major
op_ready  out  1  operand accept
res_valid  out  1  C element valid
res_data  out  SUM_W  C element, row-major
res_ready  in  1  result accept
mmio_wr  out  1  write strobe
mmio_rd  out  1  read strobe
mmio_addr  out  16  byte address
mmio_wdata  out  32  write data
mmio_wstrb  out  4  byte strobes
mmio_rdata  in  32  read data
mmio_ready  in  1  access complete

Behaviour:
- Reset: state IDLE. busy, done, err, op_ready, res_valid, mmio_wr and mmio_rd are 0. mmio_addr and mmio_wdata are 0; mmio_wstrb=4'hF; res_data=0. Reset mid-job abandons the job with no done pulse. The bus strobes are low on the cycle after rst is sampled.
- Bus rules:
  - Strobes, addr, wdata and wstrb are registered.
  - At most one access is outstanding; mmio_wr and mmio_rd are never both high.
  - A strobe stays high with stable addr/data until a rising edge where mmio_ready=1; it drops the following cycle.
  - Read data is captured from mmio_rdata on that same edge.
  - A new access starts no earlier than the cycle after the strobe drops.
  - wstrb is always 4'hF.
- States: IDLE -> (ID_CHK) -> LOAD_A -> LOAD_B -> START -> POLL -> READ_C -> RES_HOLD -> READ_C ... -> FIN -> IDLE; ERR -> FIN.
- IDLE: cmd_start=1 sets busy=1 and clears err and all counters. cmd_start while busy is ignored.
- LOAD_A / LOAD_B:
  - op_ready=1 only while no write is outstanding.
  - On op_valid&&op_ready, issue a write to A_BASE+k (or B_BASE+k) with wdata={zeros,op_data}, where k=0..N*N-1 (byte addressing, one element per address).
  - After the N*N-th write completes, advance to the next state.
  - op_ready=0 in all other states.
- START: write 32'h1 to CTRL.
- POLL:
  - Read STATUS.
  - If rdata[1]=1, go to READ_C.
  - Otherwise increment poll_cnt and reissue. The next read starts the cycle after completion; there are no idle gaps beyond the bus rule.
  - When poll_cnt reaches POLL_LIMIT without done, set err=1 and go to ERR.
- READ_C:
  - Read C_BASE+(k<<2), k=0..N*N-1.
  - On completion, load res_data=rdata[SUM_W-1:0], set res_valid=1 and enter RES_HOLD.
- RES_HOLD:
  - res_valid and res_data are held until res_ready=1 (single-entry buffer; the next read is not issued until it is accepted).
  - After the N*N-th element is accepted, go to FIN.
  - res_ready while res_valid=0 has no effect.
- FIN: done=1 for one cycle, busy=0, then IDLE. err persists.
- ERR: no further bus access; go to FIN (done still pulses).

Optional Feature:
TPU_MMIO_ID_CHECK_EN:
- Defined: after start, state ID_CHK reads TPU_BASE+0x00 before LOAD_A. On a mismatch with EXPECTED_ID, set err=1, go to ERR and issue no writes.
- Undefined: ID_CHK does not exist and IDLE goes straight to LOAD_A. EXPECTED_ID is unused.

Test Plan:
- Nominal job:
  - Stimulus: start, then stream A=1..16 and B={2,1,0,3, 1,0,2,1, 3,1,1,0, 0,2,1,1} into tpu_top.
  - Required response: 32 writes at 0x100..0x10F and 0x200..0x20F, then a CTRL write of 1.
  - C stream is 13,12,11,9 ... last element 69. A single done pulse occurs and err=0.
- Backpressure:
  - Stimulus: random op_valid gaps and res_ready held low for 5 cycles per element.
  - Required response: identical data and addresses to the nominal job. res_data is stable while waiting; no read is issued while res_valid=1.
- Slow slave:
  - Stimulus: a bus model holds mmio_ready low for 3 cycles on every access.
  - Required response: strobes and addr are held stable for 4 cycles and each access completes exactly once.
- Poll timeout:
  - Stimulus: STATUS model returns 0 forever, with POLL_LIMIT=8.
  - Required response: exactly 8 STATUS reads, err=1, done pulses, no C reads.
- Reset mid-job:
  - Stimulus: rst asserted during LOAD_B, then a new start.
  - Required response: strobes low the next cycle, busy=0, no done pulse. The rerun restarts at address 0x100.
- ID check (macro on):
  - Stimulus: EXPECTED_ID=32'hA5A5_0001 and the model returns 32'h0.
  - Required response: one read at 0x0000, err=1, done pulse, zero writes.
  - A matching ID proceeds as in the nominal job.
